// File: rtl/inject_scheduler.sv
// inject_scheduler: staggered launch of per-node dataout buffers,
// drain tracking, end-of-run pulse and traffic/watchdog error flags.
module inject_scheduler #(
  parameter int NUM_NODES = 16,
  parameter int PKT_WORDS = 30,
  parameter int GAP_W     = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] node_mask,
  input  logic [GAP_W-1:0]     stagger,
  input  logic [NUM_NODES-1:0] out_valid,
  output logic [NUM_NODES-1:0] enable,
  output logic [NUM_NODES-1:0] node_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err_unexp,
  output logic                 err_timeout
);

  localparam int CW = $clog2(PKT_WORDS + 1);
  localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FULL   = CW'(PKT_WORDS);
  localparam logic [CW-1:0] LAST_W = CW'(PKT_WORDS - 1);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_NODES - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [NUM_NODES-1:0] mask_q;
  logic [GAP_W-1:0]     stag_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 hold_q;
  logic [IW-1:0]        cur_q;
  logic [WW-1:0]        wd_q;
  logic                 armed_q;
  logic [CW-1:0]        cnt_q [NUM_NODES];

  logic accept;
  logic advance;
  logic set_en;
  logic gap_load;
  logic done_d;
  logic abort;
  logic all_done;
  logic quiet;
  logic wd_hit;

  logic [NUM_NODES-1:0] set_vec;
  logic [NUM_NODES-1:0] cnt_hit;
  logic [NUM_NODES-1:0] over_hit;

  assign accept   = (state_q == S_IDLE) && start;
  assign all_done = (node_done == mask_q);
  assign quiet    = (out_valid == '0);
  assign wd_hit   = quiet && (wd_q == WD_MAX);
  assign set_vec  = set_en ? (NUM_NODES'(1) << cur_q) : '0;

  // Per-node word events: completing word and illegal word.
  always_comb begin
    cnt_hit  = '0;
    over_hit = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      over_hit[i] = out_valid[i]
                  && (!mask_q[i] || cnt_q[i] == FULL);
      cnt_hit[i]  = out_valid[i] && mask_q[i]
                  && (cnt_q[i] == LAST_W);
    end
  end

  // Next-state and launch/terminate decisions.
  always_comb begin
    state_d  = state_q;
    advance  = 1'b0;
    set_en   = 1'b0;
    gap_load = 1'b0;
    done_d   = 1'b0;
    abort    = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          if (node_mask != '0) state_d = S_LAUNCH;
          else                 done_d  = 1'b1;
        end
      end
      (state_q == S_LAUNCH): begin
        if (hold_q) begin
          advance = (gap_q <= GAP_W'(1));
        end else if (mask_q[cur_q]) begin
          set_en   = 1'b1;
          advance  = (stag_q == '0);
          gap_load = (stag_q != '0);
        end else begin
          advance = 1'b1;
        end
        if (advance && cur_q == LAST_I) state_d = S_DRAIN;
      end
      (state_q == S_DRAIN): begin
        if (all_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          abort   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Launch cursor and stagger gap counter.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cur_q  <= '0;
      gap_q  <= '0;
      hold_q <= 1'b0;
    end else if (accept) begin
      cur_q  <= '0;
      gap_q  <= '0;
      hold_q <= 1'b0;
    end else if (state_q == S_LAUNCH) begin
      if (advance) begin
        cur_q  <= cur_q + IW'(1);
        gap_q  <= '0;
        hold_q <= 1'b0;
      end else if (gap_load) begin
        gap_q  <= stag_q;
        hold_q <= 1'b1;
      end else if (hold_q) begin
        gap_q <= gap_q - GAP_W'(1);
      end
    end
  end

  // Run capture, enables, status and watchdog.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      mask_q      <= '0;
      stag_q      <= '0;
      armed_q     <= 1'b0;
      enable      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_unexp   <= 1'b0;
      err_timeout <= 1'b0;
      wd_q        <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= done_d;
      if (accept) begin
        mask_q      <= node_mask;
        stag_q      <= stagger;
        armed_q     <= 1'b1;
        enable      <= '0;
        err_unexp   <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (armed_q && |over_hit) err_unexp <= 1'b1;
        if (abort) begin
          enable      <= '0;
          err_timeout <= 1'b1;
        end else begin
          enable <= (enable | set_vec) & ~node_done;
        end
      end
      if (state_q == S_DRAIN && quiet) wd_q <= wd_q + WW'(1);
      else                             wd_q <= '0;
    end
  end

  // Saturating per-node word counters and completion flags.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      node_done <= '0;
      for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      node_done <= '0;
      for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= '0;
    end else if (armed_q) begin
      node_done <= node_done | cnt_hit;
      for (int i = 0; i < NUM_NODES; i++) begin
        if (out_valid[i] && mask_q[i] && cnt_q[i] != FULL)
          cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inject_scheduler.sv
// tb_inject_scheduler: directed and randomized runs checked against
// a timestamp-based reference of the launch/drain schedule.
module tb_inject_scheduler;

  localparam int N   = 16;
  localparam int PKT = 30;
  localparam int TO  = 256;
  localparam longint NEVER = 64'sd1000000000000;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] node_mask = '0;
  logic [7:0]   stagger = '0;
  logic [N-1:0] out_valid = '0;
  logic [N-1:0] enable;
  logic [N-1:0] node_done;
  logic         busy;
  logic         done;
  logic         err_unexp;
  logic         err_timeout;

  inject_scheduler #(
    .NUM_NODES(N),
    .PKT_WORDS(PKT),
    .GAP_W(8),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .RST(RST),
    .start(start),
    .node_mask(node_mask),
    .stagger(stagger),
    .out_valid(out_valid),
    .enable(enable),
    .node_done(node_done),
    .busy(busy),
    .done(done),
    .err_unexp(err_unexp),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;

  logic         start_r;
  logic [N-1:0] mask_r;
  logic [N-1:0] extra_r;
  logic [N-1:0] stall;
  logic [7:0]   stag_r;
  bit           noise;

  longint       b_start [N];
  logic [N-1:0] prev_en;

  bit           m_armed;
  bit           m_run;
  longint       m_d;
  logic [N-1:0] m_mask;
  int           m_cnt [N];
  longint       m_rise [N];
  int           m_idle;

  logic [N-1:0] e_en;
  logic [N-1:0] e_nd;
  bit           e_busy;
  bit           e_done;
  bit           e_unexp;
  bit           e_to;

  bit     done_seen;
  bit     busy_seen;
  longint last_done;
  longint rise_at [N];
  longint fall_at [N];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0;
    m_run   = 0;
    m_d     = 0;
    m_mask  = '0;
    m_idle  = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]   = 0;
      m_rise[i]  = NEVER;
      b_start[i] = -1;
    end
    prev_en = '0;
    e_en    = '0;
    e_nd    = '0;
    e_busy  = 0;
    e_done  = 0;
    e_unexp = 0;
    e_to    = 0;
  endtask

  // Expected outputs of the next cycle from this cycle's inputs.
  task automatic model_step();
    logic [N-1:0] nd_now;
    logic [N-1:0] n_nd;
    logic [N-1:0] n_en;
    bit           n_unexp;
    bit           n_to;
    bit           n_done;
    longint       t;
    nd_now  = e_nd;
    n_nd    = e_nd;
    n_unexp = e_unexp;
    n_to    = e_to;
    n_done  = 0;
    if (!m_run && start) begin
      m_armed = 1;
      m_mask  = node_mask;
      n_nd    = '0;
      n_unexp = 0;
      n_to    = 0;
      m_idle  = 0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i]  = 0;
        m_rise[i] = NEVER;
      end
      if (node_mask == '0) begin
        n_done = 1;
      end else begin
        m_run = 1;
        t = cyc + 1;
        for (int i = 0; i < N; i++) begin
          if (node_mask[i]) begin
            m_rise[i] = t + 1;
            t += longint'(stagger) + 1;
          end else begin
            t += 1;
          end
        end
        m_d = t;
      end
    end else begin
      if (m_armed) begin
        for (int i = 0; i < N; i++) begin
          if (out_valid[i]) begin
            if (!m_mask[i] || m_cnt[i] == PKT) begin
              n_unexp = 1;
            end else begin
              m_cnt[i]++;
              if (m_cnt[i] == PKT) n_nd[i] = 1'b1;
            end
          end
        end
      end
      if (m_run && cyc >= m_d) begin
        if (e_nd == m_mask) begin
          n_done = 1;
          m_run  = 0;
        end else begin
          m_idle = (out_valid == '0) ? m_idle + 1 : 0;
          if (m_idle == TO) begin
            n_done = 1;
            n_to   = 1;
            m_run  = 0;
            for (int i = 0; i < N; i++) m_rise[i] = NEVER;
          end
        end
      end
    end
    for (int i = 0; i < N; i++)
      n_en[i] = (cyc + 1 >= m_rise[i]) && !nd_now[i];
    e_en    = n_en;
    e_nd    = n_nd;
    e_busy  = m_run;
    e_done  = n_done;
    e_unexp = n_unexp;
    e_to    = n_to;
  endtask

  task automatic tick();
    logic [N-1:0] ov;
    int           k;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (enable[i] && !prev_en[i]) begin
        rise_at[i] = cyc;
        if (!stall[i]) b_start[i] = cyc + 2;
      end
      if (!enable[i] && prev_en[i]) fall_at[i] = cyc;
    end
    prev_en = enable;
    ov = extra_r;
    for (int i = 0; i < N; i++) begin
      if (b_start[i] >= 0 && cyc >= b_start[i]
          && cyc < b_start[i] + PKT)
        ov[i] = 1'b1;
    end
    if (noise && $urandom_range(0, 39) == 0) begin
      k = $urandom_range(0, N - 1);
      if (!m_mask[k] || e_nd[k]) ov[k] = 1'b1;
    end
    out_valid = ov;
    start     = start_r;
    node_mask = mask_r;
    stagger   = stag_r;
    start_r   = 1'b0;
    extra_r   = '0;
    @(negedge clk);
    chk("enable", 64'(enable), 64'(e_en));
    chk("node_done", 64'(node_done), 64'(e_nd));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("err_unexp", 64'(err_unexp), 64'(e_unexp));
    chk("err_timeout", 64'(err_timeout), 64'(e_to));
    if (done) begin
      done_seen = 1;
      last_done = cyc;
    end
    if (busy) busy_seen = 1;
    if (RST) model_step();
  endtask

  task automatic run(input  logic [N-1:0] m,
                     input  logic [7:0]   g,
                     input  logic [N-1:0] stl,
                     input  bit           nz,
                     input  int           inj_k,
                     input  logic [N-1:0] inj,
                     output longint       s,
                     output longint       dc);
    int k;
    stall     = stl;
    noise     = nz;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < N; i++) begin
      rise_at[i] = -1;
      fall_at[i] = -1;
    end
    mask_r  = m;
    stag_r  = g;
    start_r = 1'b1;
    tick();
    s = cyc;
    k = 0;
    while (!done_seen && k < 20000) begin
      if (k == inj_k) extra_r = inj;
      if (nz && m_run && $urandom_range(0, 29) == 0) begin
        start_r = 1'b1;
        mask_r  = N'($urandom);
      end
      tick();
      k++;
    end
    n_cmp++;
    if (!done_seen) begin
      n_bad++;
      $display("FAIL run_done cyc=%0d got=none exp=pulse", cyc);
    end
    dc = last_done - s;
    repeat (4) tick();
    stall = '0;
    noise = 0;
  endtask

  initial begin
    longint s;
    longint dc;
    logic [N-1:0] rm;
    start_r = 1'b0;
    mask_r  = '0;
    extra_r = '0;
    stall   = '0;
    stag_r  = '0;
    noise   = 0;
    last_done = 0;
    model_reset();
    #2 RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;

    // traffic before any start is ignored
    extra_r = 16'h0010;
    tick();
    tick();
    chk("prestart_unexp", 64'(err_unexp), 64'd0);

    // single node, no stagger
    run(16'h0001, 8'd0, '0, 0, -1, '0, s, dc);
    chk("t1_done_cyc", 64'(dc), 64'd35);
    chk("t1_en_rise", 64'(rise_at[0] - s), 64'd2);
    chk("t1_en_fall", 64'(fall_at[0] - s), 64'd35);
    chk("t1_node_done", 64'(node_done), 64'h0001);
    chk("t1_err_unexp", 64'(err_unexp), 64'd0);

    // empty mask
    run(16'h0000, 8'd0, '0, 0, -1, '0, s, dc);
    chk("t3_done_cyc", 64'(dc), 64'd1);
    chk("t3_busy_seen", 64'(busy_seen), 64'd0);
    chk("t3_enable", 64'(enable), 64'd0);

    // all nodes, stagger 4
    run(16'hFFFF, 8'd4, '0, 0, -1, '0, s, dc);
    chk("t2_en1_rise", 64'(rise_at[1] - s), 64'd7);
    chk("t2_en15_rise", 64'(rise_at[15] - s), 64'd77);
    chk("t2_done_cyc", 64'(dc), 64'd110);
    chk("t2_node_done", 64'(node_done), 64'hFFFF);

    // stray word from an unselected node
    run(16'h0004, 8'd0, '0, 0, 10, 16'h0020, s, dc);
    chk("t4_done_cyc", 64'(dc), 64'd37);
    chk("t4_err_unexp", 64'(err_unexp), 64'd1);
    run(16'h0001, 8'd0, '0, 0, -1, '0, s, dc);
    chk("t4_unexp_clr", 64'(err_unexp), 64'd0);

    // stalled buffer trips the watchdog
    run(16'h0002, 8'd0, 16'h0002, 0, -1, '0, s, dc);
    chk("t5_done_cyc", 64'(dc), 64'd273);
    chk("t5_err_to", 64'(err_timeout), 64'd1);
    chk("t5_enable", 64'(enable), 64'd0);

    // reset in the middle of launch
    mask_r  = 16'h00FF;
    stag_r  = 8'd3;
    start_r = 1'b1;
    tick();
    repeat (10) tick();
    #2 RST = 1'b0;
    #1;
    chk("t6_rst_enable", 64'(enable), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_nd", 64'(node_done), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    model_reset();
    repeat (2) tick();
    RST = 1'b1;
    run(16'h00FF, 8'd3, '0, 0, -1, '0, s, dc);
    chk("t6_done_cyc", 64'(dc), 64'd63);
    chk("t6_node_done", 64'(node_done), 64'h00FF);

    // randomized runs with stray traffic and ignored starts
    for (int r = 0; r < 12; r++) begin
      rm = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      run(rm, 8'($urandom_range(0, 12)), '0, 1,
          -1, '0, s, dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
